// File: rtl/mmio_responder_pkg.sv
// Shared constants for the MMIO responder: region decode values,
// timer register offsets and CTRL register bit positions.
package mmio_responder_pkg;

  localparam logic [3:0] REGION_RAM   = 4'h0;
  localparam logic [3:0] REGION_LED   = 4'h1;
  localparam logic [3:0] REGION_SW    = 4'h2;
  localparam logic [3:0] REGION_TIMER = 4'h3;

  localparam logic TMR_COUNT = 1'b0;
  localparam logic TMR_CTRL  = 1'b1;

  localparam int RUN_BIT = 0;
  localparam int OVF_BIT = 1;

endpackage

// File: rtl/mmio_timer.sv
// Prescaled timer: a prescaler counting 0..PRESCALE-1 while run is set,
// a count that increments on every prescaler wrap, and a sticky overflow
// flag. Register select: sel=TMR_COUNT (write clears), sel=TMR_CTRL
// (bit RUN_BIT read/write, bit OVF_BIT write-1-to-clear).
module mmio_timer
  import mmio_responder_pkg::*;
#(
  parameter int N        = 16,
  parameter int PRESCALE = 50000
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         we,
  input  logic         sel,
  input  logic [N-1:0] wdata,
  output logic [N-1:0] count,
  output logic [N-1:0] ctrl
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_q;
  logic [N-1:0]  count_q;
  logic          run_q;
  logic          ovf_q;

  logic count_wr, ctrl_wr, tick;

  assign count_wr = we && (sel == TMR_COUNT);
  assign ctrl_wr  = we && (sel == TMR_CTRL);
  assign tick     = run_q && (pre_q == PW'(PRESCALE - 1));

  // Prescaler and count; a COUNT write overrides a coincident tick
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pre_q   <= '0;
      count_q <= '0;
    end else if (count_wr) begin
      pre_q   <= '0;
      count_q <= '0;
    end else if (tick) begin
      pre_q   <= '0;
      count_q <= count_q + N'(1);
    end else if (run_q) begin
      pre_q   <= pre_q + PW'(1);
    end
  end

  // Run bit and sticky overflow; an overflow beats a same-cycle clear
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      run_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (ctrl_wr) run_q <= wdata[RUN_BIT];
      if (tick && !count_wr && (count_q == '1)) ovf_q <= 1'b1;
      else if (ctrl_wr && wdata[OVF_BIT])       ovf_q <= 1'b0;
    end
  end

  // CTRL read view: only run and ovf are implemented
  always_comb begin
    ctrl          = '0;
    ctrl[RUN_BIT] = run_q;
    ctrl[OVF_BIT] = ovf_q;
  end

  assign count = count_q;

  logic unused_wdata;
  assign unused_wdata = ^wdata[N-1:2];

endmodule

// File: rtl/mmio_responder.sv
// MMIO responder beside the data RAM. Decodes ADDR[15:12] into LED,
// switch and timer regions and returns registered read data with the
// same one-cycle latency as the RAM; io_sel tells the top level to use
// rdata instead of RAM q. The timer region is built only when the macro
// MMIO_TIMER_EN is defined; otherwise region 0x3 reads as unmapped.
module mmio_responder
  import mmio_responder_pkg::*;
#(
  parameter int N        = 16,
  parameter int PRESCALE = 50000
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic [N-1:0] ADDR,
  input  logic [N-1:0] DOUT,
  input  logic         W,
  input  logic [N-1:0] SW,
  output logic [N-1:0] rdata,
  output logic         io_sel,
  output logic [N-1:0] led_out
);

  logic [3:0]   region;
  logic [N-1:0] sw_s1, sw_s2;
  logic [N-1:0] rd_nxt;
  logic         sel_nxt;

  assign region = ADDR[N-1 -: 4];

`ifdef MMIO_TIMER_EN
  logic [N-1:0] timer_count, timer_ctrl;

  mmio_timer #(.N(N), .PRESCALE(PRESCALE)) u_timer (
    .Clock (Clock),
    .Resetn(Resetn),
    .we    (W && (region == REGION_TIMER)),
    .sel   (ADDR[0]),
    .wdata (DOUT),
    .count (timer_count),
    .ctrl  (timer_ctrl)
  );

  logic unused_addr;
  assign unused_addr = ^ADDR[N-5:1];
`else
  logic unused_addr;
  assign unused_addr = ^ADDR[N-5:0];
`endif

  // LED register, written from any address in the LED region
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)                          led_out <= '0;
    else if (W && (region == REGION_LED)) led_out <= DOUT;
  end

  // Two-flop synchronizer for the asynchronous switch inputs
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= SW;
      sw_s2 <= sw_s1;
    end
  end

  // Read mux; anything outside RAM that is not mapped reads 0 with io_sel
  always_comb begin
    rd_nxt  = '0;
    sel_nxt = 1'b1;
    case (region)
      REGION_RAM: sel_nxt = 1'b0;
      REGION_LED: rd_nxt  = led_out;
      REGION_SW:  rd_nxt  = sw_s2;
`ifdef MMIO_TIMER_EN
      REGION_TIMER: rd_nxt = (ADDR[0] == TMR_CTRL) ? timer_ctrl : timer_count;
`endif
      default: ;
    endcase
  end

  // Read data register, aligned with the RAM's registered q
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rdata  <= '0;
      io_sel <= 1'b0;
    end else begin
      rdata  <= rd_nxt;
      io_sel <= sel_nxt;
    end
  end

endmodule
